bsg_manycore_ep_mem_adapter: RTL and testbench

BSG_MANYCORE_EP_MEM_ADAPTER -- requirements
Module: bsg_manycore_ep_mem_adapter

---
 rtl/bsg_manycore_ep_mem_adapter.sv | 127 ++++++++++++
 tb/tb_bsg_manycore_ep_mem_adapter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_ep_mem_adapter.sv
// rtl/bsg_manycore_ep_mem_adapter.sv - endpoint request to sync SRAM adapter with 2-slot response queue
module bsg_manycore_ep_mem_adapter #(
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 12,
  parameter int mem_els_p         = 1024,
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int oob_count_width_p = 8,
  localparam int mem_addr_width_lp = $clog2(mem_els_p),
  localparam int mask_width_lp     = data_width_p / 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          in_v_i,
  input  logic                          in_we_i,
  input  logic [addr_width_p-1:0]       in_addr_i,
  input  logic [data_width_p-1:0]       in_data_i,
  input  logic [mask_width_lp-1:0]      in_mask_i,
  input  logic [x_cord_width_p-1:0]     in_src_x_cord_i,
  input  logic [y_cord_width_p-1:0]     in_src_y_cord_i,
  output logic                          in_yumi_o,
  output logic                          returning_v_o,
  output logic [x_cord_width_p-1:0]     returning_x_cord_o,
  output logic [y_cord_width_p-1:0]     returning_y_cord_o,
  output logic [data_width_p-1:0]       returning_data_o,
  input  logic                          returning_ready_i,
  output logic                          mem_v_o,
  output logic                          mem_w_o,
  output logic [mem_addr_width_lp-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]       mem_data_o,
  output logic [mask_width_lp-1:0]      mem_mask_o,
  input  logic [data_width_p-1:0]       mem_data_i,
  output logic [oob_count_width_p-1:0]  oob_count_o
);

  localparam logic [addr_width_p:0] mem_els_lp = (addr_width_p+1)'(mem_els_p);

  logic [1:0] reserved;
  logic       deq;
  logic       in_range;

  logic                      s1_v, s1_we, s1_oob;
  logic [x_cord_width_p-1:0] s1_x;
  logic [y_cord_width_p-1:0] s1_y;

  logic [data_width_p-1:0]   fifo_data [2];
  logic [x_cord_width_p-1:0] fifo_x    [2];
  logic [y_cord_width_p-1:0] fifo_y    [2];
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                fifo_count;
  logic [data_width_p-1:0]   resp_data;

  assign deq      = returning_v_o & returning_ready_i;
  assign in_range = {1'b0, in_addr_i} < mem_els_lp;
  // A slot freed by this cycle's dequeue can be reused at once, keeping one accept per cycle.
  assign in_yumi_o = reset_n_i & in_v_i & ((reserved < 2'd2) | deq);

  assign mem_v_o    = in_yumi_o & in_range;
  assign mem_w_o    = in_we_i;
  assign mem_addr_o = in_addr_i[mem_addr_width_lp-1:0];
  assign mem_data_o = in_data_i;
  assign mem_mask_o = in_mask_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      reserved    <= 2'd0;
      oob_count_o <= '0;
    end else begin
      if (in_yumi_o && !deq)
        reserved <= reserved + 2'd1;
      else if (!in_yumi_o && deq)
        reserved <= reserved - 2'd1;
      if (in_yumi_o && !in_range && (oob_count_o != '1))
        oob_count_o <= oob_count_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v   <= 1'b0;
      s1_we  <= 1'b0;
      s1_oob <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_v   <= in_yumi_o;
      s1_we  <= in_we_i;
      s1_oob <= ~in_range;
      s1_x   <= in_src_x_cord_i;
      s1_y   <= in_src_y_cord_i;
    end
  end

  // Stores and out-of-range loads return zero as a pure credit.
  assign resp_data = (s1_we | s1_oob) ? '0 : mem_data_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (s1_v)
        wr_ptr <= ~wr_ptr;
      if (deq)
        rd_ptr <= ~rd_ptr;
      if (s1_v && !deq)
        fifo_count <= fifo_count + 2'd1;
      else if (!s1_v && deq)
        fifo_count <= fifo_count - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_v) begin
      fifo_data[wr_ptr] <= resp_data;
      fifo_x[wr_ptr]    <= s1_x;
      fifo_y[wr_ptr]    <= s1_y;
    end
  end

  assign returning_v_o      = (fifo_count != 2'd0);
  assign returning_data_o   = fifo_data[rd_ptr];
  assign returning_x_cord_o = fifo_x[rd_ptr];
  assign returning_y_cord_o = fifo_y[rd_ptr];

endmodule

// File: tb/tb_bsg_manycore_ep_mem_adapter.sv
// tb/tb_bsg_manycore_ep_mem_adapter.sv - scoreboard bench for the endpoint memory adapter
module tb_bsg_manycore_ep_mem_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_v = 1'b0, in_we = 1'b0;
  logic [11:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic [3:0]  in_x = '0, in_y = '0;
  logic        in_yumi_o;
  logic        returning_v_o;
  logic [3:0]  returning_x_cord_o, returning_y_cord_o;
  logic [31:0] returning_data_o;
  logic        ready = 1'b1;
  logic        mem_v_o, mem_w_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_data_i = '0;
  logic [7:0]  oob_count_o;

  bsg_manycore_ep_mem_adapter dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .in_v_i(in_v), .in_we_i(in_we), .in_addr_i(in_addr), .in_data_i(in_data),
    .in_mask_i(in_mask), .in_src_x_cord_i(in_x), .in_src_y_cord_i(in_y),
    .in_yumi_o(in_yumi_o),
    .returning_v_o(returning_v_o), .returning_x_cord_o(returning_x_cord_o),
    .returning_y_cord_o(returning_y_cord_o), .returning_data_o(returning_data_o),
    .returning_ready_i(ready),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i),
    .oob_count_o(oob_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  x;
    logic [3:0]  y;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] sram    [1024];
  logic [31:0] ref_mem [1024];
  int          oob_model = 0;
  int          checks = 0, failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous SRAM with byte enables.
  always @(posedge clk) begin
    if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_mask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
      end else begin
        mem_data_i <= sram[mem_addr_o];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && returning_v_o && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_response actual=%0h required=none", returning_data_o);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", returning_data_o, e.d);
        chk("rsp_x", returning_x_cord_o, e.x);
        chk("rsp_y", returning_y_cord_o, e.y);
      end
    end
  end

  // Reference: what the requester must see for a request accepted now.
  task automatic model_accept(input logic we, input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] mask, input logic [3:0] x, input logic [3:0] y);
    rsp_t e;
    bit oob;
    oob = (addr >= 12'd1024);
    e.x = x;
    e.y = y;
    e.d = 32'h0;
    if (oob) begin
      if (oob_model < 255) oob_model++;
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (mask[b]) ref_mem[addr][b*8 +: 8] = data[b*8 +: 8];
    end else begin
      e.d = ref_mem[addr];
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic we, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input logic [3:0] x, input logic [3:0] y,
                       output int acc_cyc);
    bit done;
    done = 0;
    acc_cyc = -1;
    in_v = 1'b1; in_we = we; in_addr = addr; in_data = data; in_mask = mask; in_x = x; in_y = y;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_yumi_o) begin
        done = 1;
        acc_cyc = cyc;
        chk("mem_v", mem_v_o, addr < 12'd1024);
        if (addr < 12'd1024) begin
          chk("mem_w", mem_w_o, we);
          chk("mem_addr", mem_addr_o, addr[9:0]);
          if (we) begin
            chk("mem_data", mem_data_o, data);
            chk("mem_mask", mem_mask_o, mask);
          end
        end
        model_accept(we, addr, data, mask, x, y);
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  task automatic idle();
    in_v = 1'b0;
  endtask

  task automatic latency_load(input logic [11:0] addr, input logic [3:0] x, input logic [3:0] y);
    int c;
    issue(1'b0, addr, 32'h0, 4'h0, x, y, c);
    idle();
    @(negedge clk);
    chk("latency_n1_v", returning_v_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("latency_n2_v", returning_v_o, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int c0, c1, acc;
    rsp_t snap;
    bit have_snap;

    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c, acc;
    logic [31:0] snap_d;
    logic [3:0]  snap_x, snap_y;
    bit          have_snap;

    for (int i = 0; i < 1024; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    sram[5]    = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    in_v = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_yumi", in_yumi_o, 1'b0);
    chk("reset_ret_v", returning_v_o, 1'b0);
    chk("reset_mem_v", mem_v_o, 1'b0);
    chk("reset_oob", oob_count_o, 8'd0);
    in_v = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    latency_load(12'd5, 4'd2, 4'd3);
    drain();

    issue(1'b1, 12'd7, 32'h12345678, 4'b0011, 4'd1, 4'd1, c);
    idle();
    drain();
    issue(1'b0, 12'd7, 32'h0, 4'h0, 4'd1, 4'd2, c);
    idle();
    drain();
    chk("store_low16", ref_mem[7], 32'h00005678);

    issue(1'b0, 12'd1024, 32'h0, 4'h0, 4'd4, 4'd5, c);
    idle();
    chk("oob_first", oob_count_o, 8'd1);
    drain();

    c0 = 0;
    for (int i = 0; i < 100; i++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 9) == 0) ? 12'(1024 + $urandom_range(0, 3071)) : 12'($urandom_range(0, 31));
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), c);
      if (i == 0) c0 = c;
      c1 = c;
    end
    idle();
    chk("stream_cycles", c1 - c0, 99);
    chk("stream_oob", oob_count_o, 8'(oob_model));
    drain();

    ready = 1'b0;
    acc = 0;
    have_snap = 0;
    for (int i = 0; i < 8; i++) begin
      in_v = 1'b1; in_we = 1'b0; in_addr = 12'(i); in_x = 4'(i); in_y = 4'(15 - i); in_mask = 4'h0;
      @(negedge clk);
      if (in_yumi_o) begin
        acc++;
        model_accept(1'b0, 12'(i), 32'h0, 4'h0, 4'(i), 4'(15 - i));
      end
      if (returning_v_o) begin
        if (!have_snap) begin
          have_snap = 1;
          snap_d = returning_data_o; snap_x = returning_x_cord_o; snap_y = returning_y_cord_o;
        end else begin
          chk("bp_stable_data", returning_data_o, snap_d);
          chk("bp_stable_x", returning_x_cord_o, snap_x);
          chk("bp_stable_y", returning_y_cord_o, snap_y);
        end
      end
      @(posedge clk);
      #1;
    end
    chk("bp_accepts", acc, 2);
    chk("bp_yumi_low", in_yumi_o, 1'b0);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 12'($urandom_range(0, 31)), 32'h0, 4'h0, 4'd3, 4'd3, c);
      if (i == 0) c0 = c;
      c1 = c;
    end
    idle();
    chk("bp_resume_cycles", c1 - c0, 9);
    drain();

    for (int i = 0; i < 300; i++)
      issue(1'b0, 12'(1024 + $urandom_range(0, 3071)), 32'h0, 4'h0, 4'd0, 4'd0, c);
    idle();
    chk("oob_saturate", oob_count_o, 8'd255);
    drain();

    ready = 1'b0;
    issue(1'b0, 12'd5, 32'h0, 4'h0, 4'd1, 4'd1, c);
    issue(1'b0, 12'd6, 32'h0, 4'h0, 4'd1, 4'd1, c);
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_queued", returning_v_o, 1'b1);
    reset_n = 1'b0;
    in_v = 1'b1; in_addr = 12'd5; in_we = 1'b0;
    #1;
    chk("rst_mid_ret_v", returning_v_o, 1'b0);
    chk("rst_mid_yumi", in_yumi_o, 1'b0);
    chk("rst_mid_mem_v", mem_v_o, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    in_v = 1'b0;
    ready = 1'b1;
    @(posedge clk);
    #1;
    latency_load(12'd5, 4'd9, 4'd8);
    drain();
    chk("rst_oob_cleared", oob_count_o, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
